// File: rtl/axi_host_master_pkg.sv
// axi_host_master_pkg: register map, W-channel FSM states and fixed-width entry fields for axi_host_master.
package axi_host_master_pkg;
  localparam logic [14:0] OFF_ADDR_LO = 15'h100;
  localparam logic [14:0] OFF_ADDR_HI = 15'h104;
  localparam logic [14:0] OFF_CMD     = 15'h108;
  localparam logic [14:0] OFF_WPUSH   = 15'h10C;
  localparam logic [14:0] OFF_AWPUSH  = 15'h120;
  localparam logic [14:0] OFF_ARPUSH  = 15'h124;
  localparam logic [14:0] OFF_RPOP    = 15'h130;
  localparam logic [14:0] OFF_RINFO   = 15'h134;
  localparam logic [14:0] OFF_BPOP    = 15'h140;
  localparam logic [14:0] OFF_BINFO   = 15'h144;
  localparam logic [14:0] OFF_STATUS  = 15'h150;
  localparam logic [14:0] OFF_ERRCNT  = 15'h154;
  typedef enum logic {W_IDLE, W_DATA} wstate_t;
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } beat_cfg_t;
endpackage

// File: rtl/fifo_bp.sv
// fifo_bp: show-ahead synchronous FIFO; pushes when full and pops when empty are ignored.
module fifo_bp #(
  parameter int WIDTH = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [2**LOG2_DEPTH];
  logic [LOG2_DEPTH:0] wp_q, rp_q;
  logic push, pop;
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q ^ rp_q) == {1'b1, {LOG2_DEPTH{1'b0}}};
  assign push = wr_en_i && !full_o;
  assign pop = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rp_q[LOG2_DEPTH-1:0]];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
    if (push) mem_q[wp_q[LOG2_DEPTH-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/axi_host_master.sv
// axi_host_master: host-register-driven AXI4 burst master with channel FIFOs, outstanding limits and error counting.
module axi_host_master import axi_host_master_pkg::*; #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH = 4,
  parameter int LOG2_DEPTH = 9,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [14:0]             host_addr,
  input  logic                    host_en,
  input  logic [3:0]              host_we,
  input  logic [31:0]             host_din,
  output logic [31:0]             host_dout,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [3:0]              m_awcache,
  output logic                    m_awlock,
  output logic [2:0]              m_awprot,
  output logic [3:0]              m_awqos,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic [3:0]              m_arcache,
  output logic                    m_arlock,
  output logic [2:0]              m_arprot,
  output logic [3:0]              m_arqos,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready
);
  localparam int NW = DATA_WIDTH / 32;
  localparam int WI = $clog2(NW);
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    beat_cfg_t             cfg;
    logic [ADDR_WIDTH-1:0] addr;
  } cmd_t;
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } b_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic                  last;
  } r_t;
  logic [31:0] stg_q [NW];
  logic [DATA_WIDTH-1:0] stg_flat, w_ent_q, w_head;
  logic [63:0] addr_q;
  logic [31:0] cmd_q, dout_q, rdata;
  logic aw_push_q, ar_push_q, w_push_q;
  cmd_t cmd_ent_q, aw_head, ar_head;
  b_t b_head;
  r_t r_head;
  logic rv_q, rlast_q, bv_q;
  logic [1:0] rresp_q, bresp_q;
  logic [ID_WIDTH-1:0] rid_q, bid_q;
  logic [7:0] wr_out_q, rd_out_q, beat_left_q, beat_left_d, wlen_head;
  logic [15:0] err_q;
  logic [16:0] err_sum;
  logic [2:0] ovf_q;
  wstate_t state_q, state_d;
  logic aw_full, aw_empty, ar_full, ar_empty, w_full, w_empty, wlen_full, wlen_empty;
  logic b_full, b_empty, r_full, r_empty, wlen_pop;
  logic hw, hr, aw_hs, ar_hs, w_hs, b_hs, r_hs, r_pop, b_pop, clr;
  assign hw = host_en && |host_we;
  assign hr = host_en && !(|host_we);
  assign r_pop = hw && host_addr == OFF_RPOP;
  assign b_pop = hw && host_addr == OFF_BPOP;
  assign clr = hw && host_addr == OFF_ERRCNT;
  assign aw_hs = m_awvalid && m_awready;
  assign ar_hs = m_arvalid && m_arready;
  assign w_hs = m_wvalid && m_wready;
  assign b_hs = m_bvalid && m_bready;
  assign r_hs = m_rvalid && m_rready;
  assign m_bready = !rst && !b_full;
  assign m_rready = !rst && !r_full;
  assign host_dout = dout_q;
  // wlen FIFO space is also required so every issued AW has its beat count queued
  assign m_awvalid = !aw_empty && !wlen_full && wr_out_q < 8'(MAX_OUTSTANDING);
  assign m_arvalid = !ar_empty && rd_out_q < 8'(MAX_OUTSTANDING);
  assign {m_awid, m_awlen, m_awsize, m_awaddr} = aw_head;
  assign {m_arid, m_arlen, m_arsize, m_araddr} = ar_head;
  assign {m_awburst, m_arburst} = {2'b01, 2'b01};
  assign {m_awcache, m_awlock, m_awprot, m_awqos} = '0;
  assign {m_arcache, m_arlock, m_arprot, m_arqos} = '0;
  assign m_wdata = w_head;
  assign m_wstrb = '1;
  assign m_wlast = state_q == W_DATA && beat_left_q == 8'd0;
  assign err_sum = {1'b0, err_q} + 17'(b_hs && m_bresp != 2'b00) + 17'(r_hs && m_rresp != 2'b00);
  always_comb begin
    stg_flat = '0;
    for (int k = 0; k < NW; k++) stg_flat[32*k +: 32] = stg_q[k];
  end
  always_comb begin
    state_d = state_q;
    beat_left_d = beat_left_q;
    wlen_pop = 1'b0;
    m_wvalid = 1'b0;
    if (state_q == W_IDLE) begin
      wlen_pop = !wlen_empty;
      beat_left_d = wlen_empty ? beat_left_q : wlen_head;
      state_d = wlen_empty ? W_IDLE : W_DATA;
    end else begin
      m_wvalid = !w_empty;
      beat_left_d = w_hs ? beat_left_q - 8'd1 : beat_left_q;
      state_d = (w_hs && m_wlast) ? W_IDLE : W_DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= W_IDLE;
      beat_left_q <= '0;
    end else begin
      state_q <= state_d;
      beat_left_q <= beat_left_d;
    end
  end
  always_comb begin
    rdata = '0;
    if (host_addr[14:WI+2] == '0) rdata = stg_q[host_addr[WI+1:2]];
    else case (host_addr)
      OFF_ADDR_LO: rdata = addr_q[31:0];
      OFF_ADDR_HI: rdata = addr_q[63:32];
      OFF_CMD:     rdata = cmd_q;
      OFF_RINFO:   rdata = {rv_q, rlast_q, rresp_q, {(28-ID_WIDTH){1'b0}}, rid_q};
      OFF_BINFO:   rdata = {bv_q, 1'b0, bresp_q, {(28-ID_WIDTH){1'b0}}, bid_q};
      OFF_STATUS:  rdata = {11'd0, !b_empty, !r_empty, ovf_q, rd_out_q, wr_out_q};
      OFF_ERRCNT:  rdata = {16'd0, err_q};
      default:     rdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '{default: '0};
      addr_q <= '0;
      cmd_q <= '0;
      dout_q <= '0;
      {aw_push_q, ar_push_q, w_push_q} <= '0;
      cmd_ent_q <= '0;
      w_ent_q <= '0;
      {rv_q, rlast_q, rresp_q, rid_q} <= '0;
      {bv_q, bresp_q, bid_q} <= '0;
      wr_out_q <= '0;
      rd_out_q <= '0;
      err_q <= '0;
      ovf_q <= '0;
    end else begin
      if (hr) dout_q <= rdata;
      if (hw && host_addr[14:WI+2] == '0) stg_q[host_addr[WI+1:2]] <= host_din;
      if (hw && host_addr == OFF_ADDR_LO) addr_q[31:0] <= host_din;
      if (hw && host_addr == OFF_ADDR_HI) addr_q[63:32] <= host_din;
      if (hw && host_addr == OFF_CMD) cmd_q <= host_din;
      // pushes are registered one cycle so the FIFO entry sees settled staging/ADDR/CMD values
      aw_push_q <= hw && host_addr == OFF_AWPUSH;
      ar_push_q <= hw && host_addr == OFF_ARPUSH;
      w_push_q <= hw && host_addr == OFF_WPUSH;
      cmd_ent_q <= {cmd_q[16 +: ID_WIDTH], cmd_q[7:0], cmd_q[10:8], addr_q[ADDR_WIDTH-1:0]};
      w_ent_q <= stg_flat;
      if (r_pop) begin
        rv_q <= !r_empty;
        if (!r_empty) begin
          for (int k = 0; k < NW; k++) stg_q[k] <= r_head.data[32*k +: 32];
          {rid_q, rresp_q, rlast_q} <= {r_head.id, r_head.resp, r_head.last};
        end
      end
      if (b_pop) begin
        bv_q <= !b_empty;
        if (!b_empty) {bid_q, bresp_q} <= {b_head.id, b_head.resp};
      end
      wr_out_q <= wr_out_q + 8'(aw_hs) - 8'(b_hs);
      rd_out_q <= rd_out_q + 8'(ar_hs) - 8'(r_hs && m_rlast);
      err_q <= clr ? 16'd0 : (err_sum[16] ? 16'hFFFF : err_sum[15:0]);
      ovf_q <= clr ? 3'd0 : ovf_q | {ar_push_q && ar_full, w_push_q && w_full, aw_push_q && aw_full};
    end
  end
  fifo_bp #(.WIDTH($bits(cmd_t)), .LOG2_DEPTH(LOG2_DEPTH)) u_aw_fifo (
    .clk(clk), .rstn(~rst), .wr_en_i(aw_push_q), .wr_data_i(cmd_ent_q), .full_o(aw_full),
    .rd_en_i(aw_hs), .rd_data_o(aw_head), .empty_o(aw_empty));
  fifo_bp #(.WIDTH($bits(cmd_t)), .LOG2_DEPTH(LOG2_DEPTH)) u_ar_fifo (
    .clk(clk), .rstn(~rst), .wr_en_i(ar_push_q), .wr_data_i(cmd_ent_q), .full_o(ar_full),
    .rd_en_i(ar_hs), .rd_data_o(ar_head), .empty_o(ar_empty));
  fifo_bp #(.WIDTH(DATA_WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_w_fifo (
    .clk(clk), .rstn(~rst), .wr_en_i(w_push_q), .wr_data_i(w_ent_q), .full_o(w_full),
    .rd_en_i(w_hs), .rd_data_o(w_head), .empty_o(w_empty));
  fifo_bp #(.WIDTH(8), .LOG2_DEPTH(LOG2_DEPTH)) u_wlen_fifo (
    .clk(clk), .rstn(~rst), .wr_en_i(aw_hs), .wr_data_i(m_awlen), .full_o(wlen_full),
    .rd_en_i(wlen_pop), .rd_data_o(wlen_head), .empty_o(wlen_empty));
  fifo_bp #(.WIDTH($bits(b_t)), .LOG2_DEPTH(LOG2_DEPTH)) u_b_fifo (
    .clk(clk), .rstn(~rst), .wr_en_i(b_hs), .wr_data_i({m_bid, m_bresp}), .full_o(b_full),
    .rd_en_i(b_pop), .rd_data_o(b_head), .empty_o(b_empty));
  fifo_bp #(.WIDTH($bits(r_t)), .LOG2_DEPTH(LOG2_DEPTH)) u_r_fifo (
    .clk(clk), .rstn(~rst), .wr_en_i(r_hs), .wr_data_i({m_rdata, m_rid, m_rresp, m_rlast}), .full_o(r_full),
    .rd_en_i(r_pop), .rd_data_o(r_head), .empty_o(r_empty));
endmodule
